// File: rtl/nx_dyn_delay_pkg.sv
// nx_dyn_delay_pkg: shared state encoding, field widths and default phase lengths for the delay-line port controller
package nx_dyn_delay_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, SETTLE, DONE} state_t;
    localparam int DS_W = 2;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 6;
    localparam int SETUP_CYC_D = 1;
    localparam int STROBE_CYC_D = 1;
    localparam int SETTLE_CYC_D = 2;
endpackage

// File: rtl/nx_rr_arbiter.sv
// nx_rr_arbiter: combinational round-robin pick of the first request at or after ptr (req/ptr in, one-hot gnt and idx out)
module nx_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % NUM_REQ]) begin
                idx = IW'((int'(ptr) + i) % NUM_REQ);
                gnt = NUM_REQ'(1) << ((int'(ptr) + i) % NUM_REQ);
            end
    end
endmodule

// File: rtl/nx_dyn_delay_ctrl.sv
// nx_dyn_delay_ctrl: round-robin shares one NX dynamic delay-line port (DS/DRA/DRI/DRL/DCK out, DRO/DID in) among requesters (req/ack/rdata/rid/busy)
module nx_dyn_delay_ctrl
    import nx_dyn_delay_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SETUP_CYC = SETUP_CYC_D,
    parameter int STROBE_CYC = STROBE_CYC_D,
    parameter int SETTLE_CYC = SETTLE_CYC_D
) (
    input  logic                      CK,
    input  logic                      R,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [DS_W*NUM_REQ-1:0]   req_ds,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         rid,
    output logic                      busy,
    output logic [DS_W-1:0]           DS,
    output logic [ADDR_W-1:0]         DRA,
    output logic [DATA_W-1:0]         DRI,
    output logic                      DRL,
    output logic                      DCK,
    input  logic [DATA_W-1:0]         DRO,
    input  logic [ADDR_W-1:0]         DID
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    state_t st;
    logic [3:0] cnt;
    logic [IW-1:0] ptr, gi, idx;
    logic [NUM_REQ-1:0] own, gnt;
    nx_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req(req),
        .ptr(ptr),
        .gnt(gnt),
        .idx(idx)
    );
    always_ff @(posedge CK) begin
        if (R) begin
            st <= IDLE;
            cnt <= '0;
            ptr <= '0;
            gi <= '0;
            own <= '0;
            ack <= '0;
            busy <= 1'b0;
            DS <= '0;
            DRA <= '0;
            DRI <= '0;
            DRL <= 1'b0;
            DCK <= 1'b0;
            rdata <= '0;
            rid <= '0;
        end else begin
            ack <= '0;
            case (st)
                IDLE: if (|req) begin
                    st <= SETUP;
                    cnt <= 4'(SETUP_CYC - 1);
                    gi <= idx;
                    own <= gnt;
                    busy <= 1'b1;
                    DS <= req_ds[idx*DS_W +: DS_W];
                    DRA <= req_addr[idx*ADDR_W +: ADDR_W];
                    DRI <= req_wdata[idx*DATA_W +: DATA_W];
                    DRL <= req_we[idx];
                end
                SETUP: if (cnt == 4'd0) begin
                    st <= STROBE;
                    DCK <= 1'b1;
                    cnt <= 4'(STROBE_CYC - 1);
                end else cnt <= cnt - 4'd1;
                STROBE: if (cnt == 4'd0) begin
                    DCK <= 1'b0;
                    if (SETTLE_CYC == 0) begin
                        st <= DONE;
                        rdata <= DRO;
                        rid <= DID;
                        ack <= own;
                    end else begin
                        st <= SETTLE;
                        cnt <= 4'(SETTLE_CYC - 1);
                    end
                end else cnt <= cnt - 4'd1;
                SETTLE: if (cnt == 4'd0) begin
                    st <= DONE;
                    rdata <= DRO;
                    rid <= DID;
                    ack <= own;
                end else cnt <= cnt - 4'd1;
                DONE: begin
                    st <= IDLE;
                    busy <= 1'b0;
                    ptr <= (int'(gi) == NUM_REQ - 1) ? '0 : gi + 1'b1;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
